riscv_memory_arbiter: RTL
=========================

Name: riscv_memory_arbiter

Overview:
- Parametrised N-channel arbiter between the cache clients (instruction cache, data cache, future DMA/debug) and the single memory read port and single memory write port.
- Independent read and write arbitration, each with a selectable fixed-priority or round-robin mode.
- Per-direction in-order tag FIFOs route memory responses back to the issuing channel, so memory latency may be any value of 1 cycle or more.
- Outstanding depth is configurable.

Parameters:
- CHANNELS, 2: number of client channels. Channel 0 is the instruction cache by convention. Legal range 1..8.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width.
- DEPTH, 4: maximum outstanding reads, and separately maximum outstanding writes. Power of 2, at least 2.
- RR_MODE, 1: 1 = round-robin; 0 = fixed priority, lowest index wins.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- ch_read_address  in  CHANNELS*ADDR_WIDTH  per-channel read address, channel i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- ch_read  in  CHANNELS  read request, held until granted
- ch_read_grant  out  CHANNELS  one-hot; request accepted this cycle
- ch_read_ready  out  CHANNELS  one-hot; read data valid this cycle
- ch_read_data  out  DATA_WIDTH  shared read data (equal to memory_in)
- ch_write_address  in  CHANNELS*ADDR_WIDTH  per-channel write address
- ch_write_data  in  CHANNELS*DATA_WIDTH  per-channel write data
- ch_write  in  CHANNELS  write request, held until granted
- ch_write_grant  out  CHANNELS  one-hot write accept
- ch_write_ready  out  CHANNELS  one-hot write completion
- memory_read_address  out  ADDR_WIDTH
- memory_read  out  1  read issue; memory accepts unconditionally
- memory_in  in  DATA_WIDTH  read data
- memory_read_ready  in  1  read response; responses are in issue order
- memory_write_address  out  ADDR_WIDTH
- memory_out  out  DATA_WIDTH
- memory_write  out  1  write issue
- memory_write_ready  in  1  write completion, in order
- protocol_error  out  1  sticky: response arrived with no outstanding entry

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - All outputs 0.
  - Both FIFOs emptied.
  - Round-robin pointers set to 0.
  - protocol_error cleared.
  - Any in-flight transaction is abandoned. Its late response sets protocol_error.
- Read issue, combinational within a cycle:
  - If any ch_read bit is set and the read FIFO is not full (or a response pops in the same cycle), select a winner.
  - Drive memory_read=1 and memory_read_address from the winner's address.
  - ch_read_grant = one-hot of the winner.
  - Push the winner index into the read FIFO at the clock edge.
  - Issue rate: one per cycle; zero-latency grant.
- Read arbitration:
  - RR_MODE=1: search begins at rr_ptr. After a grant to channel k, rr_ptr becomes (k+1) mod CHANNELS. rr_ptr holds while there is no grant.
  - RR_MODE=0: the lowest set index wins.
- Read response:
  - When memory_read_ready=1 and the FIFO is not empty, ch_read_ready = one-hot of the FIFO head in the same cycle. ch_read_data = memory_in. The head is popped.
- Write path:
  - Identical structure with its own FIFO and rr pointer.
  - memory_out and memory_write_address come from the winner.
  - ch_write_ready is driven from memory_write_ready against the write FIFO head.
- Read and write are fully independent. The same channel may be granted read and write in the same cycle.
- FIFO full:
  - With no pop in the cycle: no grant, memory_read=0, requests stall.
  - With a pop in the cycle: the grant is allowed, and the occupancy stays at DEPTH.
- FIFO empty plus a response: the response is dropped, no ready pulse is raised, and protocol_error is set to 1 and held until reset.
- Pointers wrap modulo DEPTH. Occupancy is counted with log2(DEPTH)+1 bits.
- Clients must hold address/data stable while their request is asserted and not yet granted. Dropping a request before grant is legal.

Test Plan:
- CHANNELS=2, RR_MODE=1, both ch_read held high for 4 cycles, memory latency 1 -> grants 01,10,01,10; ready pulses follow 1 cycle later in the same order; each ch_read_data equals memory_in at its pulse.
- RR_MODE=0, both requesting continuously -> channel 0 granted every cycle, channel 1 never granted until ch_read[0] drops, then granted the next cycle.
- DEPTH=4, memory latency 10, channel 1 reads back-to-back -> 4 grants, then grant low for 6 cycles; the 5th grant occurs in the same cycle as the 1st ready pulse.
- Simultaneous read (ch0) and write (ch1), write latency 3, read latency 1 -> both granted in cycle 0; ch_read_ready[0] at cycle 1; ch_write_ready[1] at cycle 3; memory_out = ch1 data.
- Issue 2 reads, pull reset_n low for 1 cycle, then deliver 2 memory_read_ready pulses -> no ch_read_ready pulses; protocol_error=1 after the first pulse and held.
- CHANNELS=4, RR_MODE=1, requests on 0, 2 and 3 only, rr_ptr starting at 3 -> grant order 3,0,2,3,0,2.

Source files
------------

// File: rtl/riscv_memory_arbiter.sv
// N-channel arbiter onto one memory read port and one memory write port.
// Each direction has its own arbiter and in-order tag FIFO for routing responses.
module riscv_memory_arbiter #(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RR_MODE    = 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] ch_read_address,
  input  logic [CHANNELS-1:0]            ch_read,
  output logic [CHANNELS-1:0]            ch_read_grant,
  output logic [CHANNELS-1:0]            ch_read_ready,
  output logic [DATA_WIDTH-1:0]          ch_read_data,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] ch_write_address,
  input  logic [CHANNELS*DATA_WIDTH-1:0] ch_write_data,
  input  logic [CHANNELS-1:0]            ch_write,
  output logic [CHANNELS-1:0]            ch_write_grant,
  output logic [CHANNELS-1:0]            ch_write_ready,
  output logic [ADDR_WIDTH-1:0]          memory_read_address,
  output logic                           memory_read,
  input  logic [DATA_WIDTH-1:0]          memory_in,
  input  logic                           memory_read_ready,
  output logic [ADDR_WIDTH-1:0]          memory_write_address,
  output logic [DATA_WIDTH-1:0]          memory_out,
  output logic                           memory_write,
  input  logic                           memory_write_ready,
  output logic                           protocol_error
);

  localparam int unsigned IdxW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Returns {found, index}; round-robin search starts at ptr, fixed mode at 0.
  function automatic logic [IdxW:0] pick(input logic [CHANNELS-1:0] req,
                                         input logic [IdxW-1:0]     ptr);
    logic              found;
    logic [IdxW-1:0]   win;
    logic [CHANNELS-1:0] sh;
    int unsigned       k;
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      k  = (RR_MODE != 0) ? (32'(ptr) + i) % CHANNELS : i;
      sh = req >> k;
      if (!found && sh[0]) begin
        found = 1'b1;
        win   = IdxW'(k);
      end
    end
    return {found, win};
  endfunction

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
    return IdxW'((32'(idx) + 1) % CHANNELS);
  endfunction

  logic [IdxW-1:0] rd_fifo_q [DEPTH];
  logic [IdxW-1:0] rd_fifo_d [DEPTH];
  logic [PtrW-1:0] rd_wptr_q, rd_wptr_d, rd_rptr_q, rd_rptr_d;
  logic [CntW-1:0] rd_cnt_q, rd_cnt_d;
  logic [IdxW-1:0] rd_ptr_q, rd_ptr_d, rd_win;
  logic            rd_found, rd_issue, rd_pop, rd_empty, rd_full;
  logic [CHANNELS*ADDR_WIDTH-1:0] rd_addr_sh;

  logic [IdxW-1:0] wr_fifo_q [DEPTH];
  logic [IdxW-1:0] wr_fifo_d [DEPTH];
  logic [PtrW-1:0] wr_wptr_q, wr_wptr_d, wr_rptr_q, wr_rptr_d;
  logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
  logic [IdxW-1:0] wr_ptr_q, wr_ptr_d, wr_win;
  logic            wr_found, wr_issue, wr_pop, wr_empty, wr_full;
  logic [CHANNELS*ADDR_WIDTH-1:0] wr_addr_sh;
  logic [CHANNELS*DATA_WIDTH-1:0] wr_data_sh;

  logic            err_q, err_d;

  always_comb begin
    rd_empty = (rd_cnt_q == '0);
    rd_full  = (rd_cnt_q == CntW'(DEPTH));
    rd_pop   = reset_n && memory_read_ready && !rd_empty;
    {rd_found, rd_win} = pick(ch_read, rd_ptr_q);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    rd_issue   = reset_n && rd_found && (!rd_full || rd_pop);
    rd_addr_sh = ch_read_address >> (32'(rd_win) * ADDR_WIDTH);

    memory_read         = rd_issue;
    memory_read_address = rd_issue ? rd_addr_sh[ADDR_WIDTH-1:0] : '0;
    ch_read_grant       = rd_issue ? (CHANNELS'(1) << rd_win) : '0;
    ch_read_ready       = rd_pop ? (CHANNELS'(1) << rd_fifo_q[rd_rptr_q]) : '0;
    ch_read_data        = reset_n ? memory_in : '0;

    rd_fifo_d = rd_fifo_q;
    if (rd_issue) rd_fifo_d[rd_wptr_q] = rd_win;
    rd_wptr_d = rd_wptr_q + PtrW'(rd_issue);
    rd_rptr_d = rd_rptr_q + PtrW'(rd_pop);
    rd_cnt_d  = rd_cnt_q + CntW'(rd_issue) - CntW'(rd_pop);
    rd_ptr_d  = (rd_issue && RR_MODE != 0) ? next_idx(rd_win) : rd_ptr_q;
  end

  always_comb begin
    wr_empty = (wr_cnt_q == '0);
    wr_full  = (wr_cnt_q == CntW'(DEPTH));
    wr_pop   = reset_n && memory_write_ready && !wr_empty;
    {wr_found, wr_win} = pick(ch_write, wr_ptr_q);
    wr_issue   = reset_n && wr_found && (!wr_full || wr_pop);
    wr_addr_sh = ch_write_address >> (32'(wr_win) * ADDR_WIDTH);
    wr_data_sh = ch_write_data >> (32'(wr_win) * DATA_WIDTH);

    memory_write         = wr_issue;
    memory_write_address = wr_issue ? wr_addr_sh[ADDR_WIDTH-1:0] : '0;
    memory_out           = wr_issue ? wr_data_sh[DATA_WIDTH-1:0] : '0;
    ch_write_grant       = wr_issue ? (CHANNELS'(1) << wr_win) : '0;
    ch_write_ready       = wr_pop ? (CHANNELS'(1) << wr_fifo_q[wr_rptr_q]) : '0;

    wr_fifo_d = wr_fifo_q;
    if (wr_issue) wr_fifo_d[wr_wptr_q] = wr_win;
    wr_wptr_d = wr_wptr_q + PtrW'(wr_issue);
    wr_rptr_d = wr_rptr_q + PtrW'(wr_pop);
    wr_cnt_d  = wr_cnt_q + CntW'(wr_issue) - CntW'(wr_pop);
    wr_ptr_d  = (wr_issue && RR_MODE != 0) ? next_idx(wr_win) : wr_ptr_q;

    // Any response with nothing outstanding is a protocol violation; sticky until reset.
    err_d = err_q | (memory_read_ready && rd_empty) | (memory_write_ready && wr_empty);
    protocol_error = err_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_fifo_q <= '{default: '0};
      rd_wptr_q <= '0;
      rd_rptr_q <= '0;
      rd_cnt_q  <= '0;
      rd_ptr_q  <= '0;
      wr_fifo_q <= '{default: '0};
      wr_wptr_q <= '0;
      wr_rptr_q <= '0;
      wr_cnt_q  <= '0;
      wr_ptr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      rd_fifo_q <= rd_fifo_d;
      rd_wptr_q <= rd_wptr_d;
      rd_rptr_q <= rd_rptr_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_fifo_q <= wr_fifo_d;
      wr_wptr_q <= wr_wptr_d;
      wr_rptr_q <= wr_rptr_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      err_q     <= err_d;
    end
  end

endmodule
